// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-16 control FSM with shared memory port handshake
// Optional: define MC_RETIRE_CNT_EN to enable the retired-instruction counter.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ior_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic             err,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        ADDI_EX = 4'd9,
        ADDI_WB = 4'd10,
        ERROR   = 4'd15
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout;

    // Only the three memory-access states listen to mem_ready or count wait cycles.
    assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout = waiting && !mem_ready && (wait_cnt >= WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_d = EXEC;
                    4'b0101, 4'b0110:                            state_d = MEMADR;
                    4'b0100:                                     state_d = ADDI_EX;
                    4'b1000:                                     state_d = BRANCH;
                    default:                                     state_d = ERROR;
                endcase
            end
            MEMADR:  state_d = (opcode == 4'b0101) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXEC:    state_d = RWB;
            RWB:     state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDI_EX: state_d = ADDI_WB;
            ADDI_WB: state_d = FETCH;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
        if (timeout) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (waiting && !mem_ready && !timeout) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Outputs decode the current state; FETCH and MEMWR also look at mem_ready so the
    // load/completion strobes land in the same cycle memory finishes.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        err           = 1'b0;
        state         = 4'd0;
        if (!reset) begin
            state = state_q;
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = 2'b11;
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    ior_d    = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    mem_write  = 1'b1;
                    ior_d      = 1'b1;
                    instr_done = mem_ready;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                ERROR:   err = 1'b1;
                default: err = 1'b0;
            endcase
        end
    end

`ifdef MC_RETIRE_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (instr_done) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
`else
    assign retire_cnt = '0;
`endif

endmodule
